// File: rtl/dac_sweep_ctrl.sv
// rtl/dac_sweep_ctrl.sv - DAC code sweep generator (saw-up/down, triangle, single-shot); optional pause via DAC_SWEEP_PAUSE_EN
`timescale 1ns/1ps
module dac_sweep_ctrl #(
    parameter int CODE_W  = 8,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
`ifdef DAC_SWEEP_PAUSE_EN
    input  logic               pause,
`endif
    input  logic [1:0]         mode,
    input  logic [CODE_W-1:0]  lo,
    input  logic [CODE_W-1:0]  hi,
    input  logic [CODE_W-1:0]  step,
    input  logic [DWELL_W-1:0] dwell,
    output logic [CODE_W-1:0]  code,
    output logic               upd,
    output logic               busy,
    output logic               wrap,
    output logic               done,
    output logic               err
);

    typedef enum logic [1:0] {IDLE, RUN_UP, RUN_DOWN} state_t;

    localparam logic [1:0] M_SAW_UP = 2'b00;
    localparam logic [1:0] M_SAW_DN = 2'b01;
    localparam logic [1:0] M_TRI    = 2'b10;
    localparam logic [1:0] M_SINGLE = 2'b11;

    state_t               state_q;
    logic [CODE_W-1:0]    code_q;
    logic                 upd_q, busy_q, wrap_q, done_q, err_q;
    logic [DWELL_W-1:0]   cnt_q;
    logic [1:0]           mode_q;
    logic [CODE_W-1:0]    lo_q, hi_q, step_q;
    logic [DWELL_W-1:0]   dwell_q;

    logic                 pause_w;
    logic                 start_bad;
    logic [CODE_W:0]      up_sum;
    logic [CODE_W:0]      dn_floor;
    logic [CODE_W-1:0]    up_code_d;
    logic [CODE_W-1:0]    dn_code_d;

`ifdef DAC_SWEEP_PAUSE_EN
    assign pause_w = pause;
`else
    assign pause_w = 1'b0;
`endif

    assign start_bad = (lo > hi) || (step == '0);

    // Next code candidates, computed one bit wider so the clamp never sees a wrapped value
    assign up_sum    = {1'b0, code_q} + {1'b0, step_q};
    assign up_code_d = (up_sum > {1'b0, hi_q}) ? hi_q : up_sum[CODE_W-1:0];
    assign dn_floor  = {1'b0, lo_q} + {1'b0, step_q};
    assign dn_code_d = ({1'b0, code_q} < dn_floor) ? lo_q : (code_q - step_q);

    assign code = code_q;
    assign upd  = upd_q;
    assign busy = busy_q;
    assign wrap = wrap_q;
    assign done = done_q;
    assign err  = err_q;

    // Sweep FSM: config capture, dwell timing, code stepping and registered pulse outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            code_q  <= '0;
            upd_q   <= 1'b0;
            busy_q  <= 1'b0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            mode_q  <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            step_q  <= '0;
            dwell_q <= '0;
        end else begin
            upd_q  <= 1'b0;
            wrap_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (start_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            mode_q  <= mode;
                            lo_q    <= lo;
                            hi_q    <= hi;
                            step_q  <= step;
                            dwell_q <= dwell;
                            cnt_q   <= '0;
                            err_q   <= 1'b0;
                            upd_q   <= 1'b1;
                            busy_q  <= 1'b1;
                            if (mode == M_SAW_DN) begin
                                code_q  <= hi;
                                state_q <= RUN_DOWN;
                            end else begin
                                code_q  <= lo;
                                state_q <= RUN_UP;
                            end
                        end
                    end
                end
                default: begin
                    if (stop) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else if (!pause_w) begin
                        if (cnt_q != dwell_q) begin
                            cnt_q <= cnt_q + 1'b1;
                        end else begin
                            cnt_q <= '0;
                            upd_q <= 1'b1;
                            if (state_q == RUN_UP) begin
                                if (code_q != hi_q) begin
                                    code_q <= up_code_d;
                                end else begin
                                    case (mode_q)
                                        M_TRI: begin
                                            state_q <= RUN_DOWN;
                                            code_q  <= dn_code_d;
                                        end
                                        M_SINGLE: begin
                                            state_q <= IDLE;
                                            busy_q  <= 1'b0;
                                            done_q  <= 1'b1;
                                            upd_q   <= 1'b0;
                                        end
                                        default: begin
                                            code_q <= lo_q;
                                            wrap_q <= 1'b1;
                                        end
                                    endcase
                                end
                            end else begin
                                if (code_q != lo_q) begin
                                    code_q <= dn_code_d;
                                end else if (mode_q == M_TRI) begin
                                    state_q <= RUN_UP;
                                    code_q  <= up_code_d;
                                    wrap_q  <= 1'b1;
                                end else begin
                                    code_q <= hi_q;
                                    wrap_q <= 1'b1;
                                end
                            end
                        end
                    end
                end
            endcase
        end
    end

    // M_SAW_UP is the default arm of the top-of-sweep case
    logic unused_w;
    assign unused_w = (M_SAW_UP == 2'b00);

endmodule

// File: tb/tb_dac_sweep_ctrl.sv
// tb/tb_dac_sweep_ctrl.sv - directed self-checking bench for dac_sweep_ctrl
`timescale 1ns/1ps
module tb_dac_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, stop;
    logic [1:0] mode;
    logic [7:0] lo, hi, step, dwell;
    logic [7:0] code;
    logic       upd, busy, wrap, done, err;
`ifdef DAC_SWEEP_PAUSE_EN
    logic       pause;
`endif

    int n_cmp = 0;
    int n_err = 0;

    dac_sweep_ctrl #(.CODE_W(8), .DWELL_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .stop  (stop),
`ifdef DAC_SWEEP_PAUSE_EN
        .pause (pause),
`endif
        .mode  (mode),
        .lo    (lo),
        .hi    (hi),
        .step  (step),
        .dwell (dwell),
        .code  (code),
        .upd   (upd),
        .busy  (busy),
        .wrap  (wrap),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    int saw_c[10]  = '{10, 10, 14, 14, 18, 18, 20, 20, 10, 10};
    int saw_u[10]  = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
    int saw_w[10]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    int tri_c[8]   = '{0, 100, 200, 255, 155, 55, 0, 100};

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'b00;
        lo = 8'd0; hi = 8'd0; step = 8'd0; dwell = 8'd0;
`ifdef DAC_SWEEP_PAUSE_EN
        pause = 1'b0;
`endif
        #12;
        chk("rst_code", code, 0);
        chk("rst_upd",  upd,  0);
        chk("rst_busy", busy, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_done", done, 0);
        chk("rst_err",  err,  0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // saw-up 10..20 step 4, each code held 2 cycles
        mode = 2'b00; lo = 8'd10; hi = 8'd20; step = 8'd4; dwell = 8'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("saw_code[%0d]", i), code, saw_c[i]);
            chk($sformatf("saw_upd[%0d]", i),  upd,  saw_u[i]);
            chk($sformatf("saw_wrap[%0d]", i), wrap, saw_w[i]);
            chk($sformatf("saw_busy[%0d]", i), busy, 1);
            if (i < 9) tick();
        end

        // stop and start together on an update boundary: stop wins
        stop = 1'b1; start = 1'b1;
        tick();
        stop = 1'b0; start = 1'b0;
        chk("stop_busy", busy, 0);
        chk("stop_code", code, 10);
        chk("stop_upd",  upd,  0);
        chk("stop_wrap", wrap, 0);
        chk("stop_done", done, 0);
        tick();
        chk("stop_hold_code", code, 10);
        chk("stop_hold_busy", busy, 0);

        // triangle 0..255 step 100, dwell 0
        mode = 2'b10; lo = 8'd0; hi = 8'd255; step = 8'd100; dwell = 8'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("tri_code[%0d]", i), code, tri_c[i]);
            chk($sformatf("tri_upd[%0d]", i),  upd,  1);
            chk($sformatf("tri_wrap[%0d]", i), wrap, (i == 7) ? 1 : 0);
            if (i < 7) tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("tri_stop_busy", busy, 0);
        chk("tri_stop_code", code, 100);

        // single-shot 250..255 step 3
        mode = 2'b11; lo = 8'd250; hi = 8'd255; step = 8'd3; dwell = 8'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ss_code0", code, 250);
        chk("ss_upd0",  upd,  1);
        tick();
        chk("ss_code1", code, 253);
        tick();
        chk("ss_code2", code, 255);
        chk("ss_done2", done, 0);
        chk("ss_busy2", busy, 1);
        tick();
        chk("ss_done3", done, 1);
        chk("ss_busy3", busy, 0);
        chk("ss_code3", code, 255);
        chk("ss_upd3",  upd,  0);
        tick();
        chk("ss_done4", done, 0);
        chk("ss_code4", code, 255);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ss_restart_code", code, 250);
        chk("ss_restart_busy", busy, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // illegal start lo > hi
        mode = 2'b00; lo = 8'd30; hi = 8'd20; step = 8'd1; dwell = 8'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ill_err",  err,  1);
        chk("ill_busy", busy, 0);
        chk("ill_code", code, 250);
        chk("ill_upd",  upd,  0);
        tick();
        chk("ill_err_sticky", err, 1);

        // legal saw-down start clears err
        mode = 2'b01; lo = 8'd5; hi = 8'd9; step = 8'd2; dwell = 8'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("sd_err",  err,  0);
        chk("sd_code0", code, 9);
        chk("sd_busy", busy, 1);
        chk("sd_upd0", upd,  1);
        // illegal config and start while busy must be ignored
        lo = 8'd30; hi = 8'd20; step = 8'd0; mode = 2'b10;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("sd_code1", code, 7);
        chk("sd_err1",  err,  0);
        tick();
        chk("sd_code2", code, 5);
        chk("sd_wrap2", wrap, 0);
        tick();
        chk("sd_code3", code, 9);
        chk("sd_wrap3", wrap, 1);

        // asynchronous reset mid-sweep, away from any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_code", code, 0);
        chk("arst_busy", busy, 0);
        chk("arst_upd",  upd,  0);
        chk("arst_wrap", wrap, 0);
        chk("arst_done", done, 0);
        chk("arst_err",  err,  0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("arst_rel_busy", busy, 0);
        chk("arst_rel_code", code, 0);

`ifdef DAC_SWEEP_PAUSE_EN
        // pause mid-dwell freezes code and the dwell counter
        mode = 2'b00; lo = 8'd0; hi = 8'd100; step = 8'd10; dwell = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("pz_code[%0d]", i), code, 0);
            chk($sformatf("pz_upd[%0d]", i),  upd,  0);
            chk($sformatf("pz_busy[%0d]", i), busy, 1);
        end
        pause = 1'b0;
        tick();
        chk("pz_resume_code", code, 0);
        chk("pz_resume_upd",  upd,  0);
        tick();
        chk("pz_next_code", code, 10);
        chk("pz_next_upd",  upd,  1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
